// File: rtl/rfid_poll_ctrl_if.sv
// rtl/rfid_poll_ctrl_if.sv - UART byte link between the RFID poll sequencer and the UART
//
// Ports (signals):
//   tx_data  [7:0]  command byte toward the UART transmitter
//   tx_valid        tx_data valid, held until tx_ready
//   tx_ready        transmitter accepts on tx_valid & tx_ready
//   rx_byte  [7:0]  byte from the UART receiver
//   rx_valid        one-cycle strobe qualifying rx_byte
// Modports: master = sequencer side, slave = UART side.
interface rfid_poll_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_byte,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_byte,
        output rx_valid
    );
endinterface

// File: rtl/rfid_poll_ctrl.sv
// rtl/rfid_poll_ctrl.sv - periodic single-inventory poll and reply parser for the UHF RFID reader
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   en         polling enable, sampled only in IDLE
//   link       UART byte link (master modport): command tx and reply rx
//   tag_id     last good tag byte, held between updates
//   tag_valid  one-cycle pulse when tag_id is updated
//   no_tag     one-cycle pulse when every attempt of a poll failed
//   busy       high in every state except IDLE
module rfid_poll_ctrl #(
    parameter int POLL_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int MAX_PL         = 32,
    parameter int TAG_IDX        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    rfid_poll_ctrl_if.master        link,
    output logic [7:0]              tag_id,
    output logic                    tag_valid,
    output logic                    no_tag,
    output logic                    busy
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [7:0]    PL_MAX    = 8'(MAX_PL);
    localparam logic [7:0]    TAG_POS   = 8'(TAG_IDX);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;
    typedef enum logic [2:0] {P_HUNT, P_TYPE, P_CMD, P_PLH, P_PLL, P_PAY, P_CK, P_END} pstate_t;

    state_t        state;
    pstate_t       pstate;
    pstate_t       p_next;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    retry;
    logic [2:0]    sidx;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          is_tag;
    logic [7:0]    pl_len;
    logic [7:0]    pay_cnt;
    logic [7:0]    sum;
    logic          ck_ok;
    logic [7:0]    tag_byte;
    logic          mismatch;
    logic          end_hit;
    logic          frame_good;
    logic          attempt_fail;

    assign link.tx_data  = tx_data;
    assign link.tx_valid = tx_valid;

    // Fixed single-inventory command: BB 00 22 00 00 22 7E
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = 8'hBB;
            3'd1:    cmd_byte = 8'h00;
            3'd2:    cmd_byte = 8'h22;
            3'd3:    cmd_byte = 8'h00;
            3'd4:    cmd_byte = 8'h00;
            3'd5:    cmd_byte = 8'h22;
            default: cmd_byte = 8'h7E;
        endcase
    endfunction

    // Reply parser next state. A bad checksum is not a framing error: the
    // frame runs to its 7E and is then rejected as a failed attempt.
    always_comb begin
        p_next   = pstate;
        mismatch = 1'b0;
        end_hit  = 1'b0;
        if (link.rx_valid) begin
            case (pstate)
                P_HUNT: if (link.rx_byte == 8'hBB) p_next = P_TYPE;
                P_TYPE: begin
                    if (link.rx_byte == 8'h02 || link.rx_byte == 8'h01) p_next = P_CMD;
                    else mismatch = 1'b1;
                end
                P_CMD: begin
                    if (!is_tag || link.rx_byte == 8'h22) p_next = P_PLH;
                    else mismatch = 1'b1;
                end
                P_PLH: begin
                    if (link.rx_byte == 8'h00) p_next = P_PLL;
                    else mismatch = 1'b1;
                end
                P_PLL: begin
                    if (link.rx_byte <= PL_MAX) p_next = (link.rx_byte == 8'h00) ? P_CK : P_PAY;
                    else mismatch = 1'b1;
                end
                P_PAY: if (pay_cnt == pl_len - 8'd1) p_next = P_CK;
                P_CK:  p_next = P_END;
                P_END: begin
                    if (link.rx_byte == 8'h7E) begin
                        end_hit = 1'b1;
                        p_next  = P_HUNT;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                default: p_next = P_HUNT;
            endcase
            // A mismatching BB is itself the start of a new frame
            if (mismatch) p_next = (link.rx_byte == 8'hBB) ? P_TYPE : P_HUNT;
        end
    end

    // A frame ending on the timeout cycle decides the attempt, not the timeout
    assign frame_good   = end_hit && is_tag && ck_ok && (pl_len > TAG_POS);
    assign attempt_fail = (end_hit && !frame_good) || (!end_hit && to_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pstate    <= P_HUNT;
            poll_cnt  <= '0;
            to_cnt    <= '0;
            retry     <= '0;
            sidx      <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            is_tag    <= 1'b0;
            pl_len    <= 8'h00;
            pay_cnt   <= 8'h00;
            sum       <= 8'h00;
            ck_ok     <= 1'b0;
            tag_byte  <= 8'h00;
            tag_id    <= 8'h00;
            tag_valid <= 1'b0;
            no_tag    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            no_tag    <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Timer saturates while en is low so the poll fires on the first en=1
                    if (poll_cnt != POLL_LAST) begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end else if (en) begin
                        state    <= S_SEND;
                        retry    <= '0;
                        sidx     <= '0;
                        tx_data  <= cmd_byte(3'd0);
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (tx_valid && link.tx_ready) begin
                        if (sidx == 3'd6) begin
                            tx_valid <= 1'b0;
                            to_cnt   <= '0;
                            pstate   <= P_HUNT;
                            state    <= S_WAIT;
                        end else begin
                            sidx    <= sidx + 3'd1;
                            tx_data <= cmd_byte(sidx + 3'd1);
                        end
                    end
                end
                S_WAIT: begin
                    pstate <= p_next;
                    to_cnt <= to_cnt + 1'b1;
                    if (link.rx_valid) begin
                        case (pstate)
                            P_TYPE: begin
                                is_tag <= (link.rx_byte == 8'h02);
                                sum    <= link.rx_byte;
                            end
                            P_CMD, P_PLH: sum <= sum + link.rx_byte;
                            P_PLL: begin
                                sum     <= sum + link.rx_byte;
                                pl_len  <= link.rx_byte;
                                pay_cnt <= 8'h00;
                            end
                            P_PAY: begin
                                sum     <= sum + link.rx_byte;
                                pay_cnt <= pay_cnt + 8'd1;
                                if (pay_cnt == TAG_POS) tag_byte <= link.rx_byte;
                            end
                            P_CK: ck_ok <= (link.rx_byte == sum);
                            default: ;
                        endcase
                    end
                    if (frame_good) begin
                        tag_id    <= tag_byte;
                        tag_valid <= 1'b1;
                        busy      <= 1'b0;
                        poll_cnt  <= '0;
                        state     <= S_IDLE;
                    end else if (attempt_fail) begin
                        retry <= retry + 4'd1;
                        if (retry + 4'd1 < RETRY_MAX) begin
                            state    <= S_SEND;
                            sidx     <= '0;
                            tx_data  <= cmd_byte(3'd0);
                            tx_valid <= 1'b1;
                        end else begin
                            no_tag   <= 1'b1;
                            busy     <= 1'b0;
                            poll_cnt <= '0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
